pipe_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline registers (PC, IF/ID, ID/EX, EX/MEM) of the CPU.

---
 rtl/pipe_ctrl_pkg.sv | 13 +
 rtl/pipe_hazard_ctrl_load_use.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// State ST_IRQ is only reachable when PIPE_CTRL_IRQ_EN is defined.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_IRQ     = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use comparator: flags an ID-stage source that needs the value a load in EX
// has not produced yet. Writes to r0 are discarded, so they never create a hazard.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       ex_memrd,
  input  logic [4:0] ex_rt,
  output logic       hazard
);

  logic rs_match_s;
  logic rt_match_s;

  assign rs_match_s = (ex_rt == id_rs);
  assign rt_match_s = id_uses_rt & (ex_rt == id_rt);
  assign hazard     = ex_memrd & (ex_rt != REG_ZERO) & (rs_match_s | rt_match_s);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stage enable/flush sequencer for the 5-stage pipeline, with data-memory wait timeout
// and a saturating stall counter. Optional interrupt entry is built with PIPE_CTRL_IRQ_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_jump,
  input  logic             ex_memrd,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
`ifdef PIPE_CTRL_IRQ_EN
  ,
  input  logic             irq,
  output logic             irq_ack,
  output logic             pc_sel_exc
`endif
);

  localparam int                WAIT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_e             state_r;
  state_e             state_nxt_s;
  logic [WAIT_W-1:0]  wait_cnt_r;
  logic [WAIT_W-1:0]  wait_nxt_s;
  logic               mem_err_r;
  logic               timeout_s;
  logic [CNT_W-1:0]   stall_cnt_r;
  logic               hazard_s;

  load_use_detect u_load_use (
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .ex_memrd   (ex_memrd),
    .ex_rt      (ex_rt),
    .hazard     (hazard_s)
  );

  // Stage controls and next-state decode from current state and pipeline inputs
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    exmem_we    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    state_nxt_s = state_r;
    wait_nxt_s  = wait_cnt_r;
    timeout_s   = 1'b0;
`ifdef PIPE_CTRL_IRQ_EN
    irq_ack     = 1'b0;
    pc_sel_exc  = 1'b0;
`endif
    if (rst) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      exmem_we    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      state_nxt_s = ST_RUN;
      wait_nxt_s  = {WAIT_W{1'b0}};
    end else begin
      case (state_r)
        ST_MEMWAIT: begin
          // Dropped request counts as completion; timeout releases the pipeline too
          if (!mem_req || mem_ready) begin
            state_nxt_s = ST_RUN;
            wait_nxt_s  = {WAIT_W{1'b0}};
          end else if (wait_cnt_r == WAIT_LAST) begin
            state_nxt_s = ST_RUN;
            wait_nxt_s  = {WAIT_W{1'b0}};
            timeout_s   = 1'b1;
          end else begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            exmem_we   = 1'b0;
            wait_nxt_s = wait_cnt_r + WAIT_W'(1);
          end
        end
        ST_RUN, ST_IRQ: begin
`ifdef PIPE_CTRL_IRQ_EN
          if ((state_r == ST_IRQ) && irq) begin
            state_nxt_s = ST_IRQ;
          end else begin
            state_nxt_s = ST_RUN;
          end
`else
          state_nxt_s = ST_RUN;
`endif
          wait_nxt_s = {WAIT_W{1'b0}};
          if (mem_req && !mem_ready) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            exmem_we    = 1'b0;
            state_nxt_s = ST_MEMWAIT;
          end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
`ifdef PIPE_CTRL_IRQ_EN
          end else if (irq && (state_r == ST_RUN)) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            pc_sel_exc  = 1'b1;
            irq_ack     = 1'b1;
            state_nxt_s = ST_IRQ;
`endif
          end else if (hazard_s) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
          end else if (id_jump) begin
            ifid_flush = 1'b1;
          end else begin
            ifid_flush = 1'b0;
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          wait_nxt_s  = {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // State, wait counter, sticky timeout flag and saturating stall counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      mem_err_r   <= 1'b0;
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      if (timeout_s) begin
        mem_err_r <= 1'b1;
      end else begin
        mem_err_r <= mem_err_r;
      end
      if (!pc_we && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign mem_err   = mem_err_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic,
// all compared against an abstract per-cycle model of the control rules.
module tb_pipe_hazard_ctrl;

  localparam int T   = 4;
  localparam int CW  = 4;
  localparam int SAT = 15;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    id_rs, id_rt, ex_rt;
  logic          id_uses_rt, id_jump, ex_memrd, ex_branch_taken, mem_req, mem_ready;
  logic          pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, mem_err;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_jump(id_jump), .ex_memrd(ex_memrd), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_we(exmem_we),
    .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  int cmp_n = 0;
  int bad_n = 0;

  // reference model: whether a memory wait is in progress, how many wait cycles so far
  bit m_waiting, n_waiting, m_err, n_err;
  int m_waited, n_waited, m_stall;
  bit e_pc, e_ifid, e_ex, e_ifl, e_idfl;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_n++;
    assert (obs === exp) else begin
      bad_n++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_eval();
    bit lu;
    e_pc = 1; e_ifid = 1; e_ex = 1; e_ifl = 0; e_idfl = 0;
    n_waiting = m_waiting; n_waited = m_waited; n_err = m_err;
    lu = ex_memrd && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    if (m_waiting) begin
      if (!mem_req || mem_ready) begin
        n_waiting = 0;
      end else if (m_waited >= T) begin
        n_waiting = 0;
        n_err = 1;
      end else begin
        e_pc = 0; e_ifid = 0; e_ex = 0;
        n_waited = m_waited + 1;
      end
    end else if (mem_req && !mem_ready) begin
      e_pc = 0; e_ifid = 0; e_ex = 0;
      n_waiting = 1; n_waited = 1;
    end else if (ex_branch_taken) begin
      e_ifl = 1; e_idfl = 1;
    end else if (lu) begin
      e_pc = 0; e_ifid = 0; e_idfl = 1;
    end else if (id_jump) begin
      e_ifl = 1;
    end
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rt = 1'b0; id_jump = 1'b0; ex_memrd = 1'b0;
    ex_branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // one clock: check combinational controls, clock, check registered outputs
  task automatic run_cycle(input string tag);
    #1;
    model_eval();
    chk({tag, ".pc_we"},      {31'd0, pc_we},      {31'd0, e_pc});
    chk({tag, ".ifid_we"},    {31'd0, ifid_we},    {31'd0, e_ifid});
    chk({tag, ".exmem_we"},   {31'd0, exmem_we},   {31'd0, e_ex});
    chk({tag, ".ifid_flush"}, {31'd0, ifid_flush}, {31'd0, e_ifl});
    chk({tag, ".idex_flush"}, {31'd0, idex_flush}, {31'd0, e_idfl});
    @(posedge clk);
    m_waiting = n_waiting; m_waited = n_waited; m_err = n_err;
    if (!e_pc && m_stall < SAT) m_stall++;
    #1;
    chk({tag, ".stall_cnt"}, {28'd0, stall_cnt}, m_stall);
    chk({tag, ".mem_err"},   {31'd0, mem_err},   {31'd0, m_err});
  endtask

  task automatic do_reset(input string tag);
    idle_inputs();
    rst = 1'b1;
    #1;
    chk({tag, ".rst_pc_we"},    {31'd0, pc_we},      32'd0);
    chk({tag, ".rst_ifid_we"},  {31'd0, ifid_we},    32'd0);
    chk({tag, ".rst_exmem_we"}, {31'd0, exmem_we},   32'd0);
    chk({tag, ".rst_ifid_fl"},  {31'd0, ifid_flush}, 32'd1);
    chk({tag, ".rst_idex_fl"},  {31'd0, idex_flush}, 32'd1);
    chk({tag, ".rst_stall"},    {28'd0, stall_cnt},  32'd0);
    chk({tag, ".rst_mem_err"},  {31'd0, mem_err},    32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_waiting = 0; m_waited = 0; m_err = 0; m_stall = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(posedge clk);
    #1;
    do_reset("reset");

    run_cycle("idle");

    ex_memrd = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
    run_cycle("loaduse");
    idle_inputs();
    run_cycle("after_loaduse");
    chk("loaduse_stall1", {28'd0, stall_cnt}, 32'd1);

    ex_memrd = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    run_cycle("loaduse_r0");
    ex_memrd = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    run_cycle("loaduse_rt");
    id_uses_rt = 1'b0;
    run_cycle("rt_not_used");

    ex_memrd = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; ex_branch_taken = 1'b1;
    run_cycle("branch_over_lu");
    idle_inputs();
    id_jump = 1'b1;
    run_cycle("jump");
    idle_inputs();

    do_reset("reset2");
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) run_cycle("memwait3");
    mem_ready = 1'b1;
    run_cycle("memwait3_done");
    chk("memwait3_stall", {28'd0, stall_cnt}, 32'd3);

    idle_inputs();
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) run_cycle("timeout");
    chk("timeout_err", {31'd0, mem_err}, 32'd1);
    idle_inputs();
    for (int i = 0; i < 3; i++) run_cycle("err_sticky");

    mem_req = 1'b1;
    run_cycle("mw_for_reset");
    run_cycle("mw_for_reset");
    do_reset("reset_mid_wait");
    run_cycle("after_reset_wait");

    for (int i = 0; i < 400; i++) begin
      mem_req         = ($urandom_range(0, 3) == 0);
      mem_ready       = ($urandom_range(0, 2) != 0);
      ex_branch_taken = ($urandom_range(0, 5) == 0);
      id_jump         = ($urandom_range(0, 4) == 0);
      ex_memrd        = ($urandom_range(0, 1) == 1);
      id_uses_rt      = ($urandom_range(0, 1) == 1);
      ex_rt           = 5'($urandom_range(0, 3));
      id_rs           = 5'($urandom_range(0, 3));
      id_rt           = 5'($urandom_range(0, 3));
      run_cycle("random");
    end

    idle_inputs();
    ex_memrd = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    for (int i = 0; i < 20; i++) run_cycle("saturate");
    chk("stall_saturated", {28'd0, stall_cnt}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, bad_n);
    $finish;
  end

endmodule
